// File: rtl/rsa_modexp_ct.sv
// Modular exponentiation m = c^d mod n using left-to-right square-and-multiply
// over a bit-serial interleaved modular multiplier, with an optional constant-time mode.
module rsa_modexp_ct #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 ct_mode,
  input  logic [2*WIDTH-1:0]   c,
  input  logic [2*WIDTH-1:0]   d,
  input  logic [2*WIDTH-1:0]   n,
  output logic [2*WIDTH-1:0]   m_out,
  output logic                 busy,
  output logic                 finish,
  output logic                 err
);

  localparam int K  = 2 * WIDTH;
  localparam int IW = $clog2(K);
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_e;

  state_e        state_q, state_d;
  logic [K-1:0]  c_q, c_d;
  logic [K-1:0]  d_q, d_d;
  logic [K-1:0]  n_q, n_d;
  logic          ct_q, ct_d;
  logic [K-1:0]  m_q, m_d;
  logic [K-1:0]  dummy_q, dummy_d;
  logic [K+1:0]  acc_q, acc_d;
  logic [IW-1:0] bit_q, bit_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          errp_q, errp_d;
  logic [K-1:0]  m_out_q, m_out_d;
  logic          err_q, err_d;
  logic          finish_q, finish_d;

  // Multiplier datapath temporaries
  logic [K+1:0]  n_ext;
  logic [K+1:0]  acc_dbl;
  logic [K+1:0]  acc_add;
  logic [K+1:0]  acc_step;
  logic [K-1:0]  mul_a;
  logic [K-1:0]  prod;
  logic          b_bit;
  logic          key_bit;

  // NOTE: combinational logic uses blocking '=' and assigns every output a default
  // first, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    n_ext    = {2'b00, n_q};
    mul_a    = (state_q == MUL) ? c_q : m_q;
    b_bit    = m_q[cnt_q];
    key_bit  = d_q[bit_q];

    // acc stays below n, so doubling fits in K+1 bits and one subtract reduces it
    acc_dbl  = acc_q << 1;
    if (acc_dbl >= n_ext) acc_dbl = acc_dbl - n_ext;
    acc_add  = acc_dbl + {2'b00, mul_a};
    if (acc_add >= n_ext) acc_add = acc_add - n_ext;
    acc_step = b_bit ? acc_add : acc_dbl;
    prod     = acc_step[K-1:0];

    state_d  = state_q;
    c_d      = c_q;
    d_d      = d_q;
    n_d      = n_q;
    ct_d     = ct_q;
    m_d      = m_q;
    dummy_d  = dummy_q;
    acc_d    = acc_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    errp_d   = errp_q;
    m_out_d  = m_out_q;
    err_d    = err_q;
    finish_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((n[K-1:1] == '0) || (c >= n)) begin
            errp_d  = 1'b1;
            state_d = DONE;
          end else begin
            c_d     = c;
            d_d     = d;
            n_d     = n;
            ct_d    = ct_mode;
            m_d     = {{(K-1){1'b0}}, 1'b1};
            acc_d   = '0;
            bit_d   = LAST_IDX;
            cnt_d   = LAST_IDX;
            errp_d  = 1'b0;
            state_d = SQR;
          end
        end
      end

      SQR: begin
        acc_d = acc_step;
        if (cnt_q == '0) begin
          m_d   = prod;
          acc_d = '0;
          cnt_d = LAST_IDX;
          if (ct_q || key_bit) begin
            state_d = MUL;
          end else if (bit_q == '0) begin
            state_d = DONE;
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      MUL: begin
        acc_d = acc_step;
        if (cnt_q == '0) begin
          // A zero key bit still pays for the multiply, but the product is discarded
          if (key_bit) m_d = prod;
          else         dummy_d = prod;
          acc_d = '0;
          cnt_d = LAST_IDX;
          if (bit_q == '0) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q - 1'b1;
            state_d = SQR;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        m_out_d  = errp_q ? '0 : m_q;
        err_d    = errp_q;
        finish_d = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      c_q      <= '0;
      d_q      <= '0;
      n_q      <= '0;
      ct_q     <= 1'b0;
      m_q      <= '0;
      dummy_q  <= '0;
      acc_q    <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      errp_q   <= 1'b0;
      m_out_q  <= '0;
      err_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      d_q      <= d_d;
      n_q      <= n_d;
      ct_q     <= ct_d;
      m_q      <= m_d;
      dummy_q  <= dummy_d;
      acc_q    <= acc_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      errp_q   <= errp_d;
      m_out_q  <= m_out_d;
      err_q    <= err_d;
      finish_q <= finish_d;
    end
  end

  assign m_out  = m_out_q;
  assign err    = err_q;
  assign finish = finish_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_rsa_modexp_ct.sv
// Directed bench for rsa_modexp_ct: results, latencies in both modes, error path,
// start hammering during a run and asynchronous reset mid-operation.
module tb_rsa_modexp_ct;

  localparam int WIDTH = 8;
  localparam int K     = 2 * WIDTH;
  localparam int LIMIT = 2000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         ct_mode = 1'b0;
  logic [K-1:0] c = '0;
  logic [K-1:0] d = '0;
  logic [K-1:0] n = '0;
  logic [K-1:0] m_out;
  logic         busy;
  logic         finish;
  logic         err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rsa_modexp_ct #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ct_mode (ct_mode),
    .c       (c),
    .d       (d),
    .n       (n),
    .m_out   (m_out),
    .busy    (busy),
    .finish  (finish),
    .err     (err)
  );

  function automatic longint unsigned ref_modexp(input longint unsigned b_in,
                                                 input longint unsigned e_in,
                                                 input longint unsigned m);
    longint unsigned r = 1 % m;
    longint unsigned b = b_in % m;
    longint unsigned e = e_in;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one start and measures edges from the sampling edge to the finish pulse.
  task automatic run(input string tag, input logic [K-1:0] ci, input logic [K-1:0] di,
                     input logic [K-1:0] ni, input logic cti, input logic [K-1:0] exp_m,
                     input logic exp_err, input int exp_lat, input bit hammer);
    int k;
    bit busy_ok;
    @(negedge clk);
    c = ci; d = di; n = ni; ct_mode = cti; start = 1'b1;
    @(posedge clk); #1;
    if (!hammer) start = 1'b0;
    busy_ok = (busy === 1'b1);
    k = 0;
    while (k < LIMIT) begin
      @(posedge clk); #1;
      k++;
      if (finish === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (hammer) begin
        c = K'($urandom); d = K'($urandom); n = K'($urandom); ct_mode = 1'($urandom);
      end
    end
    start = 1'b0;
    chk({tag, ".latency"}, k, exp_lat);
    chk({tag, ".m_out"}, m_out, exp_m);
    chk({tag, ".err"}, err, exp_err);
    chk({tag, ".busy_low_at_finish"}, busy, 1'b0);
    chk({tag, ".busy_during_run"}, busy_ok, 1'b1);
  endtask

  initial begin
    logic [K-1:0] r_all_ones;
    int extra;
    r_all_ones = K'(ref_modexp(5, 65535, 3233));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.m_out", m_out, 0);
    chk("reset.busy", busy, 0);
    chk("reset.finish", finish, 0);
    chk("reset.err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // RSA textbook vector, both modes
    run("fast_2753", 16'd2790, 16'd2753, 16'd3233, 1'b0, 16'd65, 1'b0, 337, 1'b0);
    run("ct_2753",   16'd2790, 16'd2753, 16'd3233, 1'b1, 16'd65, 1'b0, 513, 1'b0);

    // Constant-time invariance, then the same operands in fast mode
    run("ct_d1",     16'd5, 16'd1,     16'd3233, 1'b1, 16'd5, 1'b0, 513, 1'b0);
    run("ct_d0",     16'd5, 16'd0,     16'd3233, 1'b1, 16'd1, 1'b0, 513, 1'b0);
    run("ct_dffff",  16'd5, 16'hFFFF,  16'd3233, 1'b1, r_all_ones, 1'b0, 513, 1'b0);
    run("fast_d1",   16'd5, 16'd1,     16'd3233, 1'b0, 16'd5, 1'b0, 273, 1'b0);
    run("fast_d0",   16'd5, 16'd0,     16'd3233, 1'b0, 16'd1, 1'b0, 257, 1'b0);
    run("fast_dffff",16'd5, 16'hFFFF,  16'd3233, 1'b0, r_all_ones, 1'b0, 513, 1'b0);

    // Operand errors, then a valid run clears err
    run("err_n1",    16'd0,    16'd7, 16'd1,    1'b0, 16'd0, 1'b1, 1, 1'b0);
    run("err_c_eq_n",16'd3233, 16'd7, 16'd3233, 1'b1, 16'd0, 1'b1, 1, 1'b0);
    run("err_clear", 16'd5,    16'd1, 16'd3233, 1'b0, 16'd5, 1'b0, 273, 1'b0);

    // start held high for the whole run with scrambled operands
    run("hammer", 16'd2790, 16'd2753, 16'd3233, 1'b0, 16'd65, 1'b0, 337, 1'b1);
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (finish === 1'b1) extra++;
    end
    chk("hammer.extra_finish", extra, 0);
    chk("hammer.idle_after", busy, 0);

    // Asynchronous reset in the middle of the first squaring
    @(negedge clk);
    c = 16'd2790; d = 16'd2753; n = 16'd3233; ct_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.m_out", m_out, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.finish", finish, 0);
    chk("midrst.err", err, 0);
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (finish === 1'b1) extra++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (finish === 1'b1 || busy === 1'b1) extra++;
    end
    chk("midrst.no_finish", extra, 0);

    run("after_rst", 16'd2790, 16'd2753, 16'd3233, 1'b0, 16'd65, 1'b0, 337, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
